// File: rtl/count_sched.sv
// count_sched: round-robin scheduler sharing one saturating up-counter among NUM_REQ requesters.
// Optional macro COUNT_SCHED_HOLD_EN adds a HOLD state that keeps the grant until the owner releases req.
module count_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 3,
  parameter int MARK    = 4
) (
  input  logic                       clk,
  input  logic                       clear_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CNT_W-1:0]   len,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic [CNT_W-1:0]           cnt,
  output logic                       mark,
  output logic [NUM_REQ-1:0]         done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
`ifdef COUNT_SCHED_HOLD_EN
  localparam logic [1:0] HOLD = 2'd3;
`endif

  localparam logic [NUM_REQ-1:0] ONEHOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   MARK_V  = CNT_W'(MARK);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [1:0]         state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] done_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   tgt_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   rr_ptr_r;

  logic               win_vld_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               own_req_s;
  logic               cnt_at_tgt_s;
  logic               mark_s;
  logic [CNT_W-1:0]   len_a_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
    assign len_a_s[i] = len[i*CNT_W +: CNT_W];
  end

  // Round-robin pick: scan farthest to nearest so the requester right after rr_ptr wins.
  always_comb begin
    logic [IDX_W-1:0] idx_v;
    idx_v     = {IDX_W{1'b0}};
    win_vld_s = 1'b0;
    win_idx_s = {IDX_W{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx_v     = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      win_idx_s = req[idx_v] ? idx_v : win_idx_s;
      win_vld_s = win_vld_s | req[idx_v];
    end
  end

  assign own_req_s    = |(req & gnt_r);
  assign cnt_at_tgt_s = (cnt_r == tgt_r);
  // One mark per run: in RUN before the terminal count, or in FIN when the terminal count is MARK.
  assign mark_s = (cnt_r == MARK_V) &&
                  (((state_r == RUN) && !cnt_at_tgt_s) || (state_r == FIN));

  assign gnt  = gnt_r;
  assign done = done_r;
  assign cnt  = cnt_r;
  assign busy = (state_r != IDLE);
  assign mark = mark_s;

  // Scheduler FSM, counter, grant/done registers and round-robin pointer.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r  <= IDLE;
      gnt_r    <= {NUM_REQ{1'b0}};
      done_r   <= {NUM_REQ{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      tgt_r    <= {CNT_W{1'b0}};
      owner_r  <= {IDX_W{1'b0}};
      rr_ptr_r <= LAST_IDX;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= {NUM_REQ{1'b0}};
          cnt_r  <= {CNT_W{1'b0}};
          if (win_vld_s) begin
            state_r <= RUN;
            gnt_r   <= ONEHOT0 << win_idx_s;
            tgt_r   <= len_a_s[win_idx_s];
            owner_r <= win_idx_s;
          end
        end
        RUN: begin
          if (!own_req_s) begin
            state_r  <= IDLE;
            gnt_r    <= {NUM_REQ{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            rr_ptr_r <= owner_r;
          end else if (cnt_at_tgt_s) begin
`ifdef COUNT_SCHED_HOLD_EN
            state_r  <= HOLD;
`else
            state_r  <= FIN;
            done_r   <= gnt_r;
            rr_ptr_r <= owner_r;
`endif
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`ifdef COUNT_SCHED_HOLD_EN
        HOLD: begin
          if (!own_req_s) begin
            state_r  <= FIN;
            done_r   <= gnt_r;
            rr_ptr_r <= owner_r;
          end
        end
`endif
        FIN: begin
          state_r <= IDLE;
          done_r  <= {NUM_REQ{1'b0}};
          gnt_r   <= {NUM_REQ{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
        end
        default: begin
          state_r <= IDLE;
          done_r  <= {NUM_REQ{1'b0}};
          gnt_r   <= {NUM_REQ{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Directed self-checking bench for count_sched (NUM_REQ=4, CNT_W=3, MARK=4); honours COUNT_SCHED_HOLD_EN.
module tb_count_sched;

  localparam int MARK = 4;

  logic        clk;
  logic        clear_n;
  logic [3:0]  req;
  logic [11:0] len;
  logic [3:0]  gnt;
  logic        busy;
  logic [2:0]  cnt;
  logic        mark;
  logic [3:0]  done;

  int checks;
  int failures;
  logic [3:0] exp_q[$];

  count_sched #(.NUM_REQ(4), .CNT_W(3), .MARK(MARK)) dut (
    .clk(clk), .clear_n(clear_n), .req(req), .len(len),
    .gnt(gnt), .busy(busy), .cnt(cnt), .mark(mark), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard entry owed to the done pulse seen now.
  task automatic pop_done(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, done);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {28'd0, done}, {28'd0, e});
      chk({tag, "_gnt"}, {28'd0, gnt}, {28'd0, e});
    end
  endtask

  // Follow one full run of requester own with terminal count t; drops req at the done cycle.
  task automatic trace(input int own, input int t);
    logic [3:0] oh;
    logic       mark_exp;
    int         cnt_exp;
    oh = 4'b0001 << own;
    for (int j = 0; j <= t + 2; j++) begin
      @(negedge clk);
      cnt_exp  = (j <= t) ? j : t;
      mark_exp = ((j <= t) && (j == MARK) && (j != t)) || ((j == t + 1) && (t == MARK));
      if (j <= t + 1) begin
        chk("run_gnt", {28'd0, gnt}, {28'd0, oh});
        chk("run_busy", {31'd0, busy}, 32'd1);
        chk("run_cnt", {29'd0, cnt}, 32'(cnt_exp));
      end else begin
        chk("idle_gnt", {28'd0, gnt}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_cnt", {29'd0, cnt}, 32'd0);
      end
      chk("run_mark", {31'd0, mark}, {31'd0, mark_exp});
      if (j == t + 1) begin
        pop_done("run_done");
        req = 4'b0000;
      end else begin
        chk("no_done", {28'd0, done}, 32'd0);
      end
    end
  endtask

  // Wait for the next done pulse within budget cycles and score it.
  task automatic wait_done(input int budget, output int cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      @(negedge clk);
      cycles++;
      found = (done != 4'b0000);
    end
    if (found) begin
      pop_done("rr_done");
    end else begin
      checks++;
      failures++;
      $error("FAIL rr_timeout observed=no done expected=done within %0d cycles", budget);
    end
  endtask

  initial begin
    int cyc;
    checks   = 0;
    failures = 0;
    clear_n  = 1'b0;
    req      = 4'b0000;
    len      = 12'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {29'd0, cnt}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_mark", {31'd0, mark}, 32'd0);
    clear_n = 1'b1;
    @(negedge clk);

    // Single requester 0, len 5
    len = {3'd0, 3'd0, 3'd0, 3'd5};
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    trace(0, 5);

    // All four requesting, len 2 each, from fresh reset
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    len = {3'd2, 3'd2, 3'd2, 3'd2};
    req = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int k = 0; k < 5; k++) begin
      wait_done(20, cyc);
      chk("rr_spacing", 32'(cyc), (k == 0) ? 32'd4 : 32'd5);
    end
    req = 4'b0000;
    @(negedge clk);
    chk("rr_idle", {31'd0, busy}, 32'd0);

    // Requester 1 with len 0: one RUN cycle, no mark
    len = {3'd0, 3'd0, 3'd0, 3'd0};
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    trace(1, 0);

    // Owner 2 withdraws at cnt 3; pending requester 3 served after one IDLE cycle
    len = {3'd1, 3'd6, 3'd0, 3'd0};
    req = 4'b1100;
    exp_q.push_back(4'b1000);
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      chk("wd_gnt", {28'd0, gnt}, 32'd4);
      chk("wd_cnt", {29'd0, cnt}, 32'(j));
    end
    req = 4'b1000;
    @(negedge clk);
    chk("wd_abort_gnt", {28'd0, gnt}, 32'd0);
    chk("wd_abort_busy", {31'd0, busy}, 32'd0);
    chk("wd_abort_cnt", {29'd0, cnt}, 32'd0);
    chk("wd_abort_done", {28'd0, done}, 32'd0);
    trace(3, 1);

    // Priority after 3 is served: 0 ahead of 2
    req = 4'b0101;
    @(negedge clk);
    chk("prio_gnt", {28'd0, gnt}, 32'd1);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    // Async clear mid-run at cnt 5, then regrant from 0
    len = {3'd0, 3'd0, 3'd0, 3'd7};
    req = 4'b0001;
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      chk("clr_cnt", {29'd0, cnt}, 32'(j));
    end
    clear_n = 1'b0;
    #1;
    chk("clr_gnt", {28'd0, gnt}, 32'd0);
    chk("clr_cnt0", {29'd0, cnt}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_done", {28'd0, done}, 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    exp_q.push_back(4'b0001);
    trace(0, 7);

    // Terminal behaviour with len 3 while req stays high
    len = {3'd0, 3'd0, 3'd0, 3'd3};
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      chk("term_cnt", {29'd0, cnt}, 32'(j));
    end
`ifdef COUNT_SCHED_HOLD_EN
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("hold_gnt", {28'd0, gnt}, 32'd1);
      chk("hold_cnt", {29'd0, cnt}, 32'd3);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_done", {28'd0, done}, 32'd0);
    end
    req = 4'b0000;
    @(negedge clk);
    pop_done("hold_release_done");
`else
    @(negedge clk);
    pop_done("term_done");
    req = 4'b0000;
`endif
    @(negedge clk);
    chk("term_idle_gnt", {28'd0, gnt}, 32'd0);
    chk("term_idle_done", {28'd0, done}, 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
